// File: rtl/uart_boot_loader_pkg.sv
// Shared types and constants for the UART program loader.
package uart_boot_loader_pkg;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} rx_state_e;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = 4;

  // Rounded clock cycles per bit.
  function automatic int unsigned baud_div(int unsigned clk_hz, int unsigned baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// UART byte receiver: rx synchroniser, baud counter and byte FSM.
// UART_PARITY_EN selects 8E1 framing; otherwise 8N1.
module uart_byte_rx
  import uart_boot_loader_pkg::*;
#(
  parameter int unsigned DIV = 868
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              rx,
  output logic              byte_vld,
  output logic [BYTE_W-1:0] byte_data,
  output logic              byte_err,
  output logic              start_edge,
  output logic              active
);

  localparam int unsigned     CNT_W    = $clog2(DIV);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(DIV / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);

  logic              rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              stop_ok;
`ifdef UART_PARITY_EN
  logic              perr_q, perr_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
`ifdef UART_PARITY_EN
      perr_q    <= 1'b0;
`endif
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
`ifdef UART_PARITY_EN
      perr_q    <= perr_d;
`endif
    end
  end

`ifdef UART_PARITY_EN
  assign stop_ok = rx_sync_q && !perr_q;
`else
  assign stop_ok = rx_sync_q;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q + CNT_W'(1);
    bit_d      = bit_q;
    shift_d    = shift_q;
    byte_vld   = 1'b0;
    byte_err   = 1'b0;
    start_edge = 1'b0;
`ifdef UART_PARITY_EN
    perr_d     = perr_q;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (en && rx_prev_q && !rx_sync_q) begin
          start_edge = 1'b1;
          state_d    = StStart;
        end
      end
      StStart: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line already back high at mid start bit is a glitch.
          state_d = rx_sync_q ? StIdle : StData;
`ifdef UART_PARITY_EN
          perr_d  = 1'b0;
`endif
        end
      end
      StData: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          shift_d = {rx_sync_q, shift_q[BYTE_W-1:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_PARITY_EN
      StParity: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d   = '0;
          perr_d  = rx_sync_q != ^shift_q;
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == CNT_FULL) begin
          state_d  = StIdle;
          byte_vld = stop_ok;
          byte_err = !stop_ok;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!en) state_d = StIdle;
  end

  assign byte_data = shift_q;
  assign active    = state_q != StIdle;

endmodule

// File: rtl/uart_boot_loader.sv
// Serial program loader: packs UART bytes little-endian into addressed 32-bit word strobes
// and raises a sticky done after the line idles. UART_PARITY_EN selects 8E1 framing.
module uart_boot_loader
  import uart_boot_loader_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100_000_000,
  parameter int unsigned BAUD      = 115_200,
  parameter int unsigned IDLE_BITS = 64,
  parameter int unsigned MAX_WORDS = 16384
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rx,
  output logic [WORD_W-1:0] data_out,
  output logic [WORD_W-1:0] addr_out,
  output logic              word_vld,
  output logic              done,
  output logic              busy,
  output logic              frame_err,
  output logic              overflow
);

  localparam int unsigned       DIV        = baud_div(CLK_HZ, BAUD);
  localparam int unsigned       IDLE_LIMIT = IDLE_BITS * DIV;
  localparam int unsigned       IDLE_W     = $clog2(IDLE_LIMIT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX   = IDLE_W'(IDLE_LIMIT);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'(IDLE_LIMIT - 1);
  localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(MAX_WORDS * BYTES_PER_WORD);
  localparam logic [WORD_W-1:0] ADDR_STEP  = WORD_W'(BYTES_PER_WORD);

  logic              byte_vld, byte_err, start_edge, rx_active, fire;
  logic [BYTE_W-1:0] byte_data;

  logic [WORD_W-1:0] data_q, data_d, addr_out_q, addr_out_d, addr_q, addr_d, word_q, word_d;
  logic              vld_q, vld_d, done_q, done_d, ferr_q, ferr_d, ovf_q, ovf_d;
  logic              got_q, got_d, flush_q, flush_d;
  logic [1:0]        k_q, k_d;
  logic [IDLE_W-1:0] idle_q, idle_d;

  uart_byte_rx #(
    .DIV (DIV)
  ) u_byte_rx (
    .clk        (clk),
    .rst        (rst),
    .en         (!done_q),
    .rx         (rx),
    .byte_vld   (byte_vld),
    .byte_data  (byte_data),
    .byte_err   (byte_err),
    .start_edge (start_edge),
    .active     (rx_active)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q     <= '0;
      addr_out_q <= '0;
      addr_q     <= '0;
      word_q     <= '0;
      vld_q      <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      got_q      <= 1'b0;
      flush_q    <= 1'b0;
      k_q        <= '0;
      idle_q     <= '0;
    end else begin
      data_q     <= data_d;
      addr_out_q <= addr_out_d;
      addr_q     <= addr_d;
      word_q     <= word_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
      ovf_q      <= ovf_d;
      got_q      <= got_d;
      flush_q    <= flush_d;
      k_q        <= k_d;
      idle_q     <= idle_d;
    end
  end

  always_comb begin
    data_d     = data_q;
    addr_out_d = addr_out_q;
    addr_d     = addr_q;
    word_d     = word_q;
    vld_d      = 1'b0;
    done_d     = done_q | flush_q;
    ferr_d     = ferr_q | byte_err;
    ovf_d      = ovf_q;
    got_d      = got_q | byte_vld;
    flush_d    = 1'b0;
    k_d        = k_q;
    idle_d     = idle_q;
    fire       = 1'b0;

    // Idle timer saturates; it only fires once a byte has been seen.
    if (rx_active || start_edge) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IDLE_W'(1);
      fire   = (idle_q == IDLE_LAST) && got_q && !done_q;
    end

    if (byte_vld) begin
      if (addr_q == ADDR_LIMIT) begin
        ovf_d = 1'b1;
      end else begin
        word_d[{k_q, 3'b000} +: BYTE_W] = byte_data;
        k_d = k_q + 2'd1;
        if (k_q == 2'd3) begin
          data_d     = word_d;
          addr_out_d = addr_q;
          vld_d      = 1'b1;
          addr_d     = addr_q + ADDR_STEP;
          word_d     = '0;
        end
      end
    end else if (fire) begin
      if (k_q != 2'd0) begin
        // Unfilled bytes of the partial word are already zero.
        data_d     = word_q;
        addr_out_d = addr_q;
        vld_d      = 1'b1;
        addr_d     = addr_q + ADDR_STEP;
        word_d     = '0;
        k_d        = '0;
        flush_d    = 1'b1;
      end else begin
        done_d = 1'b1;
      end
    end
  end

  assign data_out  = data_q;
  assign addr_out  = addr_out_q;
  assign word_vld  = vld_q;
  assign done      = done_q;
  assign frame_err = ferr_q;
  assign overflow  = ovf_q;
  assign busy      = (rx_active || k_q != 2'd0) && !done_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader with a scaled bit period (DIV = 16 cycles).
module tb_uart_boot_loader;

  localparam int unsigned CLK_HZ    = 16;
  localparam int unsigned BAUD      = 1;
  localparam int unsigned IDLE_BITS = 4;
  localparam int unsigned MAX_WORDS = 4;
  localparam int          DIV       = 16;
  localparam int          IDLE_CYC  = IDLE_BITS * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx  = 1'b1;
  logic [31:0] data_out, addr_out;
  logic        word_vld, done, busy, frame_err, overflow;

  int     checks = 0;
  int     errors = 0;
  longint cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_boot_loader #(
    .CLK_HZ    (CLK_HZ),
    .BAUD      (BAUD),
    .IDLE_BITS (IDLE_BITS),
    .MAX_WORDS (MAX_WORDS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .data_out  (data_out),
    .addr_out  (addr_out),
    .word_vld  (word_vld),
    .done      (done),
    .busy      (busy),
    .frame_err (frame_err),
    .overflow  (overflow)
  );

  // Strobe monitor
  logic [31:0] got_data[$];
  logic [31:0] got_addr[$];
  longint      last_vld_cyc = 0;
  longint      done_cyc     = 0;
  bit          done_seen    = 0;

  always @(negedge clk) begin
    if (word_vld) begin
      got_data.push_back(data_out);
      got_addr.push_back(addr_out);
      last_vld_cyc = cyc;
    end
    if (done && !done_seen) begin
      done_seen = 1;
      done_cyc  = cyc;
    end
  end

  // Reference model: byte stream -> list of expected {data, addr} words
  logic [31:0] exp_data[$];
  logic [31:0] exp_addr[$];
  int          m_k, m_words;
  logic [31:0] m_buf;
  bit          m_got, m_ferr, m_ovf;

  function automatic void model_reset();
    exp_data.delete();
    exp_addr.delete();
    m_k = 0; m_words = 0; m_buf = 0; m_got = 0; m_ferr = 0; m_ovf = 0;
  endfunction

  function automatic void model_byte(logic [7:0] b, bit ok);
    if (!ok) begin
      m_ferr = 1;
      return;
    end
    m_got = 1;
    if (m_words == MAX_WORDS) begin
      m_ovf = 1;
      return;
    end
    m_buf = m_buf | (32'(b) << (8 * m_k));
    m_k++;
    if (m_k == 4) begin
      exp_data.push_back(m_buf);
      exp_addr.push_back(32'(4 * m_words));
      m_words++;
      m_k   = 0;
      m_buf = 0;
    end
  endfunction

  function automatic void model_idle();
    if (m_got && m_k != 0) begin
      exp_data.push_back(m_buf);
      exp_addr.push_back(32'(4 * m_words));
      m_k = 0;
    end
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    @(negedge clk) rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
`ifdef UART_PARITY_EN
    rx = ^b;
    repeat (DIV) @(negedge clk);
`endif
    rx = stop_ok;
    repeat (DIV) @(negedge clk);
    if (!stop_ok) begin
      rx = 1'b1;
      repeat (DIV) @(negedge clk);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " data_out"}, data_out, 0);
    check({tag, " addr_out"}, addr_out, 0);
    check({tag, " word_vld"}, 32'(word_vld), 0);
    check({tag, " done"}, 32'(done), 0);
    check({tag, " busy"}, 32'(busy), 0);
    check({tag, " frame_err"}, 32'(frame_err), 0);
    check({tag, " overflow"}, 32'(overflow), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    got_data.delete();
    got_addr.delete();
    done_seen = 0;
    model_reset();
    check_reset_state("reset");
  endtask

  task automatic compare_stream(input string tag);
    check({tag, " strobe count"}, 32'(got_data.size()), 32'(exp_data.size()));
    for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
      check($sformatf("%s word%0d data", tag, i), got_data[i], exp_data[i]);
      check($sformatf("%s word%0d addr", tag, i), got_addr[i], exp_addr[i]);
    end
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < IDLE_CYC + 100 && !done; i++) @(negedge clk);
    check({tag, " done"}, 32'(done), 1);
  endtask

  typedef struct packed {
    int          n;
    logic [63:0] bytes;
    int          bad;
    bit          idle;
    int          nstr;
    logic [31:0] d0, a0, d1, a1;
    bit          edone;
    bit          eferr;
  } vec_t;

  vec_t vecs[4];

  initial begin
    vecs[0] = '{n: 4, bytes: 64'h0000_0000_0000_0513, bad: -1, idle: 0, nstr: 1,
                d0: 32'h0000_0513, a0: 0, d1: 0, a1: 0, edone: 0, eferr: 0};
    vecs[1] = '{n: 8, bytes: 64'h0807_0605_0403_0201, bad: -1, idle: 1, nstr: 2,
                d0: 32'h0403_0201, a0: 0, d1: 32'h0807_0605, a1: 4, edone: 1, eferr: 0};
    vecs[2] = '{n: 5, bytes: 64'h0000_00EE_DDCC_BBAA, bad: -1, idle: 1, nstr: 2,
                d0: 32'hDDCC_BBAA, a0: 0, d1: 32'h0000_00EE, a1: 4, edone: 1, eferr: 0};
    vecs[3] = '{n: 5, bytes: 64'h0000_0044_3322_115A, bad: 0, idle: 0, nstr: 1,
                d0: 32'h4433_2211, a0: 0, d1: 0, a1: 0, edone: 0, eferr: 1};

    // Directed vectors
    for (int v = 0; v < 4; v++) begin
      do_reset();
      for (int i = 0; i < vecs[v].n; i++) send_byte(vecs[v].bytes[8*i +: 8], i != vecs[v].bad);
      exp_data.push_back(vecs[v].d0);
      exp_addr.push_back(vecs[v].a0);
      if (vecs[v].nstr > 1) begin
        exp_data.push_back(vecs[v].d1);
        exp_addr.push_back(vecs[v].a1);
      end
      if (vecs[v].idle) wait_done($sformatf("vec%0d", v));
      else repeat (20) @(negedge clk);
      repeat (3) @(negedge clk);
      compare_stream($sformatf("vec%0d", v));
      check($sformatf("vec%0d done", v), 32'(done), 32'(vecs[v].edone));
      check($sformatf("vec%0d frame_err", v), 32'(frame_err), 32'(vecs[v].eferr));
      check($sformatf("vec%0d overflow", v), 32'(overflow), 0);
      check($sformatf("vec%0d busy", v), 32'(busy), 0);
      if (vecs[v].idle && (vecs[v].n % 4) != 0)
        check($sformatf("vec%0d done after flush", v), 32'(done_cyc), 32'(last_vld_cyc + 1));
    end

    // Short glitch on rx: no byte, busy while in start check, then idle again
    do_reset();
    @(negedge clk) rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check("glitch busy mid", 32'(busy), 1);
    repeat (2 * DIV) @(negedge clk);
    check("glitch busy after", 32'(busy), 0);
    check("glitch frame_err", 32'(frame_err), 0);
    check("glitch strobes", 32'(got_data.size()), 0);

    // Reset in the middle of a data phase
    do_reset();
    send_byte(8'hA1, 1); send_byte(8'hA2, 1); send_byte(8'hA3, 1); send_byte(8'hA4, 1);
    send_byte(8'hB1, 1);
    @(negedge clk) rx = 1'b0;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (3 * DIV) @(negedge clk);
    do_reset();
    send_byte(8'h11, 1); send_byte(8'h22, 1); send_byte(8'h33, 1); send_byte(8'h44, 1);
    exp_data.push_back(32'h4433_2211);
    exp_addr.push_back(0);
    repeat (10) @(negedge clk);
    compare_stream("rst mid-frame");

    // Randomized streams; trial 0 forces an overflow
    for (int t = 0; t < 4; t++) begin
      int n;
      do_reset();
      n = (t == 0) ? 18 : int'($urandom_range(1, 20));
      for (int i = 0; i < n; i++) begin
        logic [7:0] b;
        bit         ok;
        b  = 8'($urandom);
        ok = (t == 0) || ($urandom_range(0, 7) != 0);
        model_byte(b, ok);
        send_byte(b, ok);
      end
      model_idle();
      if (m_got) begin
        wait_done($sformatf("rand%0d", t));
      end else begin
        repeat (IDLE_CYC + 100) @(negedge clk);
        check($sformatf("rand%0d no done", t), 32'(done), 0);
      end
      repeat (3) @(negedge clk);
      compare_stream($sformatf("rand%0d", t));
      check($sformatf("rand%0d frame_err", t), 32'(frame_err), 32'(m_ferr));
      check($sformatf("rand%0d overflow", t), 32'(overflow), 32'(m_ovf));
      check($sformatf("rand%0d busy", t), 32'(busy), 0);
      if (m_got) begin
        // rx must be ignored once done
        for (int i = 0; i < 4; i++) send_byte(8'($urandom), 1);
        repeat (IDLE_CYC + 20) @(negedge clk);
        check($sformatf("rand%0d post-done strobes", t), 32'(got_data.size()),
              32'(exp_data.size()));
        check($sformatf("rand%0d post-done busy", t), 32'(busy), 0);
        check($sformatf("rand%0d post-done done", t), 32'(done), 1);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
